// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - MIPS instruction encoder and sequential program loader
// Define ENC_OPCHECK_EN to drop (and flag) bundles whose opcode is not in the ISA table.
module mips_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BASE_ADDR);

  state_t            state, state_nx;
  logic              accept, wr_en, is_hlt, is_rtype, full;
  logic [ADDR_W-1:0] tgt_addr;
  logic [31:0]       enc_word;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    is_hlt   = (in_op == 6'h3F);
    is_rtype = (in_op <= 6'h05);
    if (is_hlt)
      enc_word = {6'h3F, 26'b0};
    else if (is_rtype)
      enc_word = {in_op, in_rs, in_rt, in_rd, 11'b0};
    else
      enc_word = {in_op, in_rs, in_rt, in_imm};
  end

`ifdef ENC_OPCHECK_EN
  logic op_ok;
  assign op_ok = is_hlt | is_rtype | ((in_op >= 6'h08) && (in_op <= 6'h0E));
  assign wr_en = accept & op_ok;
`else
  assign wr_en = accept;
`endif

  // A write still on the port bumps mem_addr at this edge, so the new word lands one further on.
  assign tgt_addr = (mem_we && (mem_addr != LAST_ADDR)) ? mem_addr + 1'b1 : mem_addr;
  assign full     = (tgt_addr == LAST_ADDR);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (wr_en && (is_hlt || full)) state_nx = DONE;
      DONE:    if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= START_ADDR;
      mem_wdata <= 32'b0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      state  <= state_nx;
      mem_we <= wr_en;
      err    <= 1'b0;
      if (wr_en) begin
        mem_wdata <= enc_word;
        err       <= full & ~is_hlt;
      end
`ifdef ENC_OPCHECK_EN
      if (accept && !op_ok) err <= 1'b1;
`endif
      if (start && (state != LOAD)) begin
        mem_addr <= START_ADDR;
        count    <= '0;
      end else if (mem_we) begin
        count <= count + 1'b1;
        if (mem_addr != LAST_ADDR) mem_addr <= mem_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - table, corner-case and random checks of mips_prog_loader
module tb_mips_prog_loader;
  localparam int ADDR_W    = 4;
  localparam int MEM_DEPTH = 12;
  localparam int BASE_ADDR = 0;
  localparam int LAST      = MEM_DEPTH - 1;

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        in_op = '0;
  logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0]       in_imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done, err;
  logic [ADDR_W:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model state: loading/done flags, next write address, words written.
  bit m_loading = 0;
  bit m_done = 0;
  int m_addr = BASE_ADDR;
  int m_count = 0;

  always #5 clk1 = ~clk1;

  mips_prog_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .count(count), .err(err)
  );

  typedef struct {
    bit          restart;
    int          op, rs, rt, rd, imm;
    logic [31:0] exp_word;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int op, input int rs, input int rt, input int rd, input int imm);
    longint w;
    if (op == 63) w = 64'hFC00_0000;
    else if (op <= 5) w = op * (64'd1 << 26) + rs * (64'd1 << 21) + rt * (64'd1 << 16) + rd * (64'd1 << 11);
    else w = op * (64'd1 << 26) + rs * (64'd1 << 21) + rt * (64'd1 << 16) + imm;
    return w[31:0];
  endfunction

  function automatic bit op_known(input int op);
`ifdef ENC_OPCHECK_EN
    return (op <= 5) || (op >= 8 && op <= 14) || (op == 63);
`else
    return (op >= 0);
`endif
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), m_addr);
    check({tag, "_count"}, 32'(count), m_count);
    check({tag, "_busy"}, 32'(busy), 32'(m_loading));
    check({tag, "_done"}, 32'(done), 32'(m_done));
    check({tag, "_ready"}, 32'(in_ready), 32'(m_loading));
  endtask

  // Entered just after a negedge; leaves just after the next negedge.
  task automatic send(input int op, input int rs, input int rt, input int rd, input int imm);
    bit acc;
    int tgt;
    check("send_ready", 32'(in_ready), 32'(m_loading));
    acc = m_loading;
    in_valid = 1'b1;
    in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 16'(imm);
    @(posedge clk1);
    #1 in_valid = 1'b0;
    @(negedge clk1);
    if (acc && op_known(op)) begin
      tgt = m_addr;
      check("wr_we", 32'(mem_we), 32'd1);
      check("wr_addr", 32'(mem_addr), tgt);
      check("wr_data", mem_wdata, ref_word(op, rs, rt, rd, imm));
      check("wr_err", 32'(err), 32'(tgt == LAST && op != 63));
      check("wr_count", 32'(count), m_count);
      m_count++;
      if (m_addr != LAST) m_addr++;
      if (op == 63 || tgt == LAST) begin
        m_loading = 0;
        m_done = 1;
      end
    end else begin
      check("nw_we", 32'(mem_we), 32'd0);
      check("nw_err", 32'(err), 32'(acc));
      check("nw_addr", 32'(mem_addr), m_addr);
      check("nw_count", 32'(count), m_count);
    end
    check("send_busy", 32'(busy), 32'(m_loading));
    check("send_done", 32'(done), 32'(m_done));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    check_quiet("idle");
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk1);
    #1 start = 1'b0;
    if (!m_loading) begin
      m_loading = 1; m_done = 0; m_addr = BASE_ADDR; m_count = 0;
    end
    @(negedge clk1);
    check_quiet("start");
  endtask

  task automatic model_reset();
    m_loading = 0; m_done = 0; m_addr = BASE_ADDR; m_count = 0;
  endtask

  task automatic rst_after_accept();
    in_valid = 1'b1;
    in_op = 6'h00; in_rs = 5'd7; in_rt = 5'd8; in_rd = 5'd9; in_imm = 16'h0;
    @(posedge clk1);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk1);
    check_quiet("rstmid");
    check("rstmid_wdata", mem_wdata, 32'd0);
    @(posedge clk1);
    @(negedge clk1);
    check("rstmid_we2", 32'(mem_we), 32'd0);
    rst = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    int op, k, r;
    tbl[0] = '{1, 6'h00, 1, 2, 3, 0, 32'h0022_1800};
    tbl[1] = '{0, 6'h3F, 31, 31, 31, 16'hFFFF, 32'hFC00_0000};
    tbl[2] = '{1, 6'h0A, 0, 5, 0, 16'hFFF6, 32'h2805_FFF6};
    tbl[3] = '{0, 6'h0E, 5, 0, 0, 3, 32'h38A0_0003};
    tbl[4] = '{0, 6'h3F, 0, 0, 0, 0, 32'hFC00_0000};
    tbl[5] = '{1, 6'h05, 31, 31, 31, 0, 32'h17FF_F800};
    tbl[6] = '{0, 6'h09, 2, 3, 0, 16'h1234, 32'h2443_1234};
    tbl[7] = '{0, 6'h01, 3, 4, 5, 16'hFFFF, 32'h0464_2800};
    tbl[8] = '{0, 6'h3F, 1, 1, 1, 1, 32'hFC00_0000};

    repeat (2) @(negedge clk1);
    check_quiet("reset");
    check("reset_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    idle();
    send(6'h00, 1, 1, 1, 0);

    foreach (tbl[i]) begin
      if (tbl[i].restart) begin
        idle();
        do_start();
      end
      send(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm);
      check("tbl_word", mem_wdata, tbl[i].exp_word);
      check("tbl_addr", 32'(mem_addr), 32'(m_addr == LAST && m_done ? m_addr : m_addr - 1));
    end
    idle();
    check("tbl_final_count", 32'(count), 32'd4);

    do_start();
    for (int i = 0; i < MEM_DEPTH; i++) send(6'h00, i % 32, 1, 2, 0);
    check("full_done", 32'(done), 32'd1);
    send(6'h00, 3, 3, 3, 0);
    idle();
    check("full_count", 32'(count), MEM_DEPTH);

    do_start();
    for (int i = 0; i < MEM_DEPTH - 1; i++) send(6'h0A, 1, 2, 0, i);
    send(6'h3F, 0, 0, 0, 0);
    idle();

    do_start();
    send(6'h20, 0, 0, 0, 0);
    send(6'h3F, 0, 0, 0, 0);
    idle();
`ifdef ENC_OPCHECK_EN
    check("opchk_count", 32'(count), 32'd1);
`else
    check("opchk_count", 32'(count), 32'd2);
`endif

    do_start();
    send(6'h02, 1, 2, 3, 0);
    send(6'h03, 4, 5, 6, 0);
    do_start();
    send(6'h04, 7, 8, 9, 0);
    send(6'h3F, 0, 0, 0, 0);
    idle();
    do_start();
    check("restart_addr", 32'(mem_addr), BASE_ADDR);

    send(6'h00, 1, 2, 3, 0);
    rst_after_accept();
    idle();
    do_start();
    send(6'h08, 1, 2, 0, 16'h0040);
    send(6'h3F, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) do_start();
      else if (r <= 2) idle();
      else begin
        k = $urandom_range(0, 15);
        if (k <= 5) op = k;
        else if (k <= 12) op = k + 2;
        else if (k == 13) op = 63;
        else if (k == 14) op = 16 + $urandom_range(0, 46);
        else op = 6 + $urandom_range(0, 1);
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
